// File: rtl/execute_muldiv.sv
// ============================================================================
// Module   : execute_muldiv
// Purpose  : Iterative RV32M multiply/divide unit for the execute stage.
//            Radix-2 shift-add multiply, restoring divide, optional
//            combinational multiplier, valid/ready handshake and flush.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module execute_muldiv #(
  parameter int WIDTH    = 32,
  parameter int FAST_MUL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       func3,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  localparam int c_CNT_W = $clog2(WIDTH) + 1;

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_MUL  = 2'd1;
  localparam logic [1:0] c_DIV  = 2'd2;
  localparam logic [1:0] c_DONE = 2'd3;

  localparam logic [c_CNT_W-1:0] c_CNT_INIT = c_CNT_W'(WIDTH);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
  localparam logic [WIDTH-1:0]   c_MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]         r_state;
  logic [1:0]         w_nextState;
  logic [2:0]         r_func3;
  logic [c_CNT_W-1:0] r_count;
  logic [2*WIDTH-1:0] r_acc;      // MUL: {partial sum, multiplier}; DIV: {remainder, dividend/quotient}
  logic [WIDTH-1:0]   r_operand;  // MUL: |multiplicand|; DIV: |divisor|
  logic               r_negate;   // final result needs two's-complement negation
  logic [WIDTH-1:0]   r_result;

  // Request-side decode, done on the live inputs during the accept edge
  logic               w_accept;
  logic               w_signA;
  logic               w_signB;
  logic               w_negA;
  logic               w_negB;
  logic [WIDTH-1:0]   w_absA;
  logic [WIDTH-1:0]   w_absB;
  logic               w_resNeg;
  logic               w_divZero;
  logic               w_overflow;
  logic [WIDTH-1:0]   w_specialRes;
  logic               w_fastEn;
  logic [2*WIDTH-1:0] w_fastProd;

  // Iteration datapath
  logic [WIDTH:0]     w_mulSum;
  logic [2*WIDTH-1:0] w_mulNext;
  logic [WIDTH:0]     w_remShift;
  logic               w_geq;
  logic [WIDTH-1:0]   w_trial;
  logic [2*WIDTH-1:0] w_divNext;
  logic [WIDTH-1:0]   w_divPick;
  logic [WIDTH-1:0]   w_divRes;

  // Sign-correct a magnitude product and select the low or high half
  function automatic logic [WIDTH-1:0] mulResult(input logic [2*WIDTH-1:0] prod,
                                                 input logic               neg,
                                                 input logic [2:0]         f);
    logic [2*WIDTH-1:0] p;
    p = neg ? (~prod + 1'b1) : prod;
    return (f == 3'd0) ? p[WIDTH-1:0] : p[2*WIDTH-1:WIDTH];
  endfunction

  assign w_accept = (r_state == c_IDLE) && !reset && in_valid && !flush;

  // MULH, MULHSU, DIV, REM treat rs1 as signed; MULH, DIV, REM treat rs2 as signed
  assign w_signA  = func3[2] ? !func3[0] : ((func3 == 3'd1) || (func3 == 3'd2));
  assign w_signB  = func3[2] ? !func3[0] : (func3 == 3'd1);
  assign w_negA   = w_signA && op_a[WIDTH-1];
  assign w_negB   = w_signB && op_b[WIDTH-1];
  assign w_absA   = w_negA ? (~op_a + 1'b1) : op_a;
  assign w_absB   = w_negB ? (~op_b + 1'b1) : op_b;
  // Remainder follows the dividend sign; everything else is the xor of signs
  assign w_resNeg = (func3[2] && func3[1]) ? w_negA : (w_negA ^ w_negB);

  assign w_divZero    = func3[2] && (op_b == '0);
  assign w_overflow   = func3[2] && !func3[0] && (op_a == c_MIN_NEG) && (op_b == '1);
  assign w_specialRes = w_divZero ? (func3[1] ? op_a : '1)
                                  : (func3[1] ? '0 : op_a);

  generate
    if (FAST_MUL != 0) begin : g_fastMul
      assign w_fastEn   = !func3[2];
      assign w_fastProd = {{WIDTH{1'b0}}, w_absA} * {{WIDTH{1'b0}}, w_absB};
    end else begin : g_iterMul
      assign w_fastEn   = 1'b0;
      assign w_fastProd = '0;
    end
  endgenerate

  // One shift-add step: add multiplicand when the multiplier LSB is set, shift right
  assign w_mulSum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_operand} : '0);
  assign w_mulNext = {w_mulSum, r_acc[WIDTH-1:1]};

  // One restoring step: shift next dividend bit into the remainder, trial subtract.
  // The shifted remainder is below twice the divisor, so a WIDTH-bit difference suffices.
  assign w_remShift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_geq      = (w_remShift >= {1'b0, r_operand});
  assign w_trial    = w_remShift[WIDTH-1:0] - r_operand;
  assign w_divNext  = {(w_geq ? w_trial : w_remShift[WIDTH-1:0]), r_acc[WIDTH-2:0], w_geq};
  assign w_divPick  = r_func3[1] ? w_divNext[2*WIDTH-1:WIDTH] : w_divNext[WIDTH-1:0];
  assign w_divRes   = r_negate ? (~w_divPick + 1'b1) : w_divPick;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic; flush overrides every transition
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      c_IDLE: begin
        if (w_accept) begin
          if (w_divZero || w_overflow || w_fastEn) begin
            w_nextState = c_DONE;
          end else begin
            w_nextState = func3[2] ? c_DIV : c_MUL;
          end
        end
      end
      c_MUL, c_DIV: begin
        if (r_count == c_CNT_ONE) begin
          w_nextState = c_DONE;
        end
      end
      c_DONE: begin
        if (out_ready) begin
          w_nextState = c_IDLE;
        end
      end
      default: w_nextState = c_IDLE;
    endcase
    if (flush) begin
      w_nextState = c_IDLE;
    end
  end

  // Handshake outputs decoded from the current state
  always_comb begin
    in_ready  = (r_state == c_IDLE) && !reset;
    busy      = (r_state != c_IDLE);
    out_valid = (r_state == c_DONE);
    result    = r_result;
  end

  // Operand capture, iteration steps and result write
  always_ff @(posedge clk) begin
    if (reset) begin
      r_func3   <= '0;
      r_count   <= '0;
      r_acc     <= '0;
      r_operand <= '0;
      r_negate  <= 1'b0;
      r_result  <= '0;
    end else if (flush) begin
      r_count <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_accept) begin
            r_func3  <= func3;
            r_negate <= w_resNeg;
            if (w_divZero || w_overflow) begin
              r_result <= w_specialRes;
            end else if (w_fastEn) begin
              r_result <= mulResult(w_fastProd, w_resNeg, func3);
            end else begin
              r_count   <= c_CNT_INIT;
              r_acc     <= {{WIDTH{1'b0}}, (func3[2] ? w_absA : w_absB)};
              r_operand <= func3[2] ? w_absB : w_absA;
            end
          end
        end
        c_MUL: begin
          r_acc   <= w_mulNext;
          r_count <= r_count - c_CNT_ONE;
          if (r_count == c_CNT_ONE) begin
            r_result <= mulResult(w_mulNext, r_negate, r_func3);
          end
        end
        c_DIV: begin
          r_acc   <= w_divNext;
          r_count <= r_count - c_CNT_ONE;
          if (r_count == c_CNT_ONE) begin
            r_result <= w_divRes;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_execute_muldiv.sv
// ============================================================================
// Module   : tb_execute_muldiv
// Purpose  : Directed self-checking bench for execute_muldiv: a WIDTH=32
//            iterative unit, a WIDTH=16 iterative unit and a WIDTH=16 unit
//            with the combinational multiplier.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_execute_muldiv;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        outReady = 1'b0;
  logic [2:0]  inValid = '0;
  logic [2:0]  func3 = '0;
  logic [31:0] opA = '0;
  logic [31:0] opB = '0;

  logic        inReady0, outValid0, busy0;
  logic [31:0] result0;
  logic        inReady1, outValid1, busy1;
  logic [15:0] result1;
  logic        inReady2, outValid2, busy2;
  logic [15:0] result2;

  int          curSel = 0;
  logic        curInReady, curOutValid, curBusy;
  logic [31:0] curResult;

  int nChecks = 0;
  int nErrors = 0;

  always #5 clk = ~clk;

  execute_muldiv #(.WIDTH(32), .FAST_MUL(0)) dut32 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(inValid[0]), .in_ready(inReady0),
    .func3(func3), .op_a(opA), .op_b(opB), .out_valid(outValid0), .out_ready(outReady),
    .result(result0), .busy(busy0)
  );

  execute_muldiv #(.WIDTH(16), .FAST_MUL(0)) dut16 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(inValid[1]), .in_ready(inReady1),
    .func3(func3), .op_a(opA[15:0]), .op_b(opB[15:0]), .out_valid(outValid1), .out_ready(outReady),
    .result(result1), .busy(busy1)
  );

  execute_muldiv #(.WIDTH(16), .FAST_MUL(1)) dut16f (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(inValid[2]), .in_ready(inReady2),
    .func3(func3), .op_a(opA[15:0]), .op_b(opB[15:0]), .out_valid(outValid2), .out_ready(outReady),
    .result(result2), .busy(busy2)
  );

  // Route the selected instance to a common set of observation signals
  always_comb begin
    case (curSel)
      1: begin
        curInReady = inReady1; curOutValid = outValid1; curBusy = busy1; curResult = {16'h0, result1};
      end
      2: begin
        curInReady = inReady2; curOutValid = outValid2; curBusy = busy2; curResult = {16'h0, result2};
      end
      default: begin
        curInReady = inReady0; curOutValid = outValid0; curBusy = busy0; curResult = result0;
      end
    endcase
  end

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present one request, scramble the inputs after the accept edge and count
  // edges (accept edge = 1) until out_valid rises, bounded at 200.
  task automatic issueWait(input int sel, input logic [2:0] f, input logic [31:0] a,
                           input logic [31:0] b, output int lat);
    curSel = sel;
    @(negedge clk);
    checkEq("in_ready before issue", {31'b0, curInReady}, 32'd1);
    func3 = f; opA = a; opB = b; inValid[sel] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    inValid[sel] = 1'b0; func3 = ~f; opA = 32'hA5A5_5A5A; opB = 32'h0;
    lat = 1;
    while (!curOutValid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    checkEq("out_valid rose", {31'b0, curOutValid}, 32'd1);
  endtask

  task automatic runOp(input int sel, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] expRes, input int expLat, input string tag);
    int lat;
    issueWait(sel, f, a, b, lat);
    checkEq({tag, " latency"}, lat, expLat);
    checkEq({tag, " result"}, curResult, expRes);
    outReady = 1'b1;
    @(negedge clk);
    outReady = 1'b0;
    checkEq({tag, " retire {out_valid,in_ready,busy}"}, {29'b0, curOutValid, curInReady, curBusy}, 32'b010);
  endtask

  initial begin
    int lat;
    int badCycles;
    logic sawValid;

    // Reset with a request pending
    reset = 1'b1; inValid = 3'b111; func3 = 3'd0; opA = 32'd5; opB = 32'd6;
    repeat (3) @(negedge clk);
    checkEq("reset in_ready", {29'b0, inReady0, inReady1, inReady2}, 32'd0);
    checkEq("reset out_valid", {29'b0, outValid0, outValid1, outValid2}, 32'd0);
    checkEq("reset busy", {29'b0, busy0, busy1, busy2}, 32'd0);
    checkEq("reset result", result0, 32'd0);
    inValid = '0; reset = 1'b0;
    @(negedge clk);
    checkEq("in_ready after reset", {29'b0, inReady0, inReady1, inReady2}, 32'b111);

    // WIDTH=32 iterative multiply
    runOp(0, 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, "MULH min*min");
    runOp(0, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, "MULHSU -1*max");
    runOp(0, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, "MULHU max*max");
    runOp(0, 3'd1, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 33, "MULH -1*2");
    runOp(0, 3'd0, 32'd7,         32'd6,         32'd42,        33, "MUL 7*6");
    runOp(0, 3'd0, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFF1, 33, "MUL -3*5");

    // WIDTH=32 iterative divide
    runOp(0, 3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33, "DIV -7/2");
    runOp(0, 3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33, "REM -7%2");
    runOp(0, 3'd5, 32'd100,       32'd7,         32'd14,        33, "DIVU 100/7");
    runOp(0, 3'd7, 32'd100,       32'd7,         32'd2,         33, "REMU 100%7");
    runOp(0, 3'd4, 32'd20,        32'hFFFF_FFFD, 32'hFFFF_FFFA, 33, "DIV 20/-3");

    // Single-edge special cases
    runOp(0, 3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, 1, "DIVU 5/0");
    runOp(0, 3'd6, 32'd5,         32'd0,         32'd5,         1, "REM 5/0");
    runOp(0, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "DIV overflow");
    runOp(0, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1, "REM overflow");

    // Backpressure: hold the result while a new request waits, then retire
    issueWait(0, 3'd6, 32'd20, 32'hFFFF_FFFD, lat);
    checkEq("REM bp latency", lat, 33);
    checkEq("REM bp result", curResult, 32'd2);
    inValid[0] = 1'b1; func3 = 3'd0; opA = 32'd1; opB = 32'd1;
    badCycles = 0;
    repeat (10) begin
      @(negedge clk);
      if (curResult !== 32'd2 || curOutValid !== 1'b1 || curInReady !== 1'b0) badCycles++;
    end
    checkEq("stable under backpressure", badCycles, 0);
    outReady = 1'b1;
    @(negedge clk);
    inValid[0] = 1'b0; outReady = 1'b0;
    checkEq("no accept on retire edge {out_valid,in_ready,busy}",
            {29'b0, curOutValid, curInReady, curBusy}, 32'b010);

    // Flush in the middle of a divide
    curSel = 0;
    @(negedge clk);
    func3 = 3'd4; opA = 32'd1000; opB = 32'd3; inValid[0] = 1'b1;
    @(negedge clk);
    inValid[0] = 1'b0;
    repeat (3) @(negedge clk);
    checkEq("mid-div {busy,in_ready}", {30'b0, curBusy, curInReady}, 32'b10);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checkEq("flush {busy,out_valid,in_ready}", {29'b0, curBusy, curOutValid, curInReady}, 32'b001);
    sawValid = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (curOutValid) sawValid = 1'b1;
    end
    checkEq("no out_valid after flush", {31'b0, sawValid}, 32'd0);
    func3 = 3'd5; opA = 32'd9; opB = 32'd2; inValid[0] = 1'b1; flush = 1'b1;
    @(negedge clk);
    inValid[0] = 1'b0; flush = 1'b0;
    checkEq("request with flush ignored", {31'b0, curBusy}, 32'd0);
    runOp(0, 3'd5, 32'd100, 32'd7, 32'd14, 33, "DIVU after flush");

    // WIDTH=16 instances
    runOp(1, 3'd3, 32'h0000_FFFF, 32'h0000_FFFF, 32'h0000_FFFE, 17, "W16 MULHU");
    runOp(1, 3'd4, 32'h0000_FFF9, 32'd2,         32'h0000_FFFD, 17, "W16 DIV -7/2");
    runOp(2, 3'd0, 32'd3,         32'd5,         32'd15,        1,  "W16 fast MUL 3*5");
    runOp(2, 3'd1, 32'h0000_8000, 32'h0000_8000, 32'h0000_4000, 1,  "W16 fast MULH");
    runOp(2, 3'd7, 32'd100,       32'd7,         32'd2,         17, "W16 fast-unit REMU");

    $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/execute_muldiv.md
Name: execute_muldiv

Overview:
- Parametrised iterative RV32M multiply/divide unit for the execute stage of the pipelined CPU.
- Sits beside the single-cycle ALU and handles opcode 0110011 with func7 = 0000001; the execute stage routes those instructions here instead of to the ALU.
- Generalises the fixed-width, single-cycle execute path with three additions:
  - configurable data width;
  - multi-cycle operation with a valid/ready handshake, so the stage can stall;
  - a flush input so a pipeline redirect can kill an in-flight operation.

Parameters:
- WIDTH, 32, operand/result width in bits; even, ≥ 8.
- FAST_MUL, 0: 1 → MUL/MULH/MULHSU/MULHU use a combinational multiplier (1-edge latency); 0 → iterative shift-add.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- flush  in  1  abort in-flight op, synchronous.
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept; high only in IDLE.
- func3  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- op_a  in  WIDTH  rs1 value (multiplicand / dividend).
- op_b  in  WIDTH  rs2 value (multiplier / divisor).
- out_valid  out  1  result available.
- out_ready  in  1  consumer (writeback) takes result.
- result  out  WIDTH  result, held stable while out_valid.
- busy  out  1  state ≠ IDLE; drives the pipeline stall.

Behaviour:
- States: IDLE, MUL, DIV, DONE. Priority per edge: reset > flush > normal operation.
- Reset: state IDLE, result 0, out_valid 0, busy 0, counter 0. in_ready is 0 while reset is high.
- Accept: on the edge where in_valid && in_ready && !flush:
  - latch func3, op_a, op_b;
  - inputs may change freely afterwards.
- Operand signing:
  - Signed ops (MULH, DIV, REM) take absolute values of both operands.
  - MULHSU takes the absolute value of op_a only.
  - Record the result sign: product = sa^sb; quotient = sa^sb; remainder = sign of dividend.
- Special cases go IDLE→DONE in 1 edge:
  - Divide by zero: DIV/DIVU → all ones; REM/REMU → op_a.
  - Signed overflow (DIV/REM with op_a = 1 followed by zeros, op_b = all ones): DIV → op_a; REM → 0.
  - FAST_MUL=1 multiply ops also complete in 1 edge.
- Normal path:
  - Accept edge: IDLE→MUL or DIV, counter := WIDTH.
  - Each edge in MUL/DIV performs one radix-2 step and decrements the counter.
  - The edge with counter == 1 performs the last step, applies the sign correction, writes result, and goes to DONE.
  - Total: out_valid rises exactly WIDTH+1 edges after the accept edge.
- MUL step: 2·WIDTH-bit accumulator, shift-add on the LSB of the multiplier.
  - MUL returns the low WIDTH bits.
  - MULH* return the high WIDTH bits of the sign-corrected 2·WIDTH product.
- DIV step: restoring division (shift remainder left, trial subtract, set quotient bit).
  - Results match RISC-V truncation toward zero.
- DONE:
  - out_valid = 1; result held.
  - out_ready = 1 → IDLE next edge, out_valid drops.
  - out_ready = 0 → stay in DONE indefinitely.
- Throughput: one op per accept-to-retire cycle. No acceptance in DONE, even when out_ready is high that edge.
- Flush:
  - In any state, next state is IDLE and out_valid = 0.
  - result retains its old value (don't-care).
  - A request presented with flush is not accepted.
- in_valid while busy: ignored (no queuing); the requester must hold it.
- All arithmetic is modulo 2^WIDTH; the counter width is clog2(WIDTH)+1.

Test Plan:
- Reset with in_valid=1, func3=0 → in_ready=0, out_valid=0, result=0. Release reset → in_ready=1 on the next cycle.
- WIDTH=32, FAST_MUL=0:
  - MULH 0x80000000 × 0x80000000 → result 0x40000000, out_valid exactly 33 edges after accept.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
  - MUL 7 × 6 → 42.
- DIV −7 / 2 → 0xFFFFFFFD; REM −7 / 2 → 0xFFFFFFFF; DIVU 100 / 7 → 14; REMU 100 / 7 → 2. Each takes 33 edges.
- Special cases:
  - DIVU 5 / 0 → 0xFFFFFFFF after 1 edge.
  - REM 5 / 0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
  - REM 0x80000000 / 0xFFFFFFFF → 0.
- Backpressure and flush:
  - Hold out_ready=0 for 10 cycles after out_valid → result and out_valid stable and in_ready=0; then out_ready=1 → IDLE next edge.
  - Assert flush at cycle 5 of a DIV → IDLE next edge, out_valid never rises, and a new request is accepted afterwards.
- WIDTH=16 instance:
  - MULHU 0xFFFF × 0xFFFF → 0xFFFE after 17 edges.
  - FAST_MUL=1 MUL 3 × 5 → 15 after 1 edge.
